// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access stage behind the ALU of the 16-bit pipeline.
//                Pass-through ops retire in one cycle; loads/stores run one
//                req/ack access against the shared SRAM while stalling
//                upstream. One writeback record is emitted per instruction.
//                Optional macro MEM_TIMEOUT_EN adds an access timeout that
//                aborts after MEM_TIMEOUT unacknowledged REQ cycles and sets
//                the sticky err flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  in_op,
    input  logic [15:0] in_addr,
    input  logic [15:0] in_wdata,
    input  logic [3:0]  in_rd,
    input  logic        in_wen,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [3:0]  out_rd,
    output logic        out_wen,
    output logic        err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_STORE = 2'b10;

    state_t      r_state, w_state;
    logic [15:0] r_addr, w_addr;
    logic [15:0] r_wdata, w_wdata;
    logic [3:0]  r_rd, w_rd;
    logic        r_wen, w_wen;
    logic        r_we, w_we;
    logic        r_out_valid, w_out_valid;
    logic [15:0] r_out_data, w_out_data;
    logic [3:0]  r_out_rd, w_out_rd;
    logic        r_out_wen, w_out_wen;
    logic        r_err, w_err;
    logic        w_timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int              CW         = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]   c_CNT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Count unacknowledged REQ cycles; any cycle outside REQ clears the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != S_REQ) begin
            r_cnt <= '0;
        end else if (!mem_ack) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Last allowed REQ cycle: no ack on this edge means the count hits the limit
    assign w_timeout = (r_state == S_REQ) && (r_cnt == c_CNT_LAST);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MEM_TIMEOUT == 0);
    assign w_timeout    = 1'b0;
`endif

    // Next-state and next-output decode; registers hold unless changed below
    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_rd        = r_rd;
        w_wen       = r_wen;
        w_we        = r_we;
        w_out_valid = 1'b0;
        w_out_data  = r_out_data;
        w_out_rd    = r_out_rd;
        w_out_wen   = r_out_wen;
        w_err       = r_err;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_op == c_OP_LOAD || in_op == c_OP_STORE) begin
                        w_state = S_REQ;
                        w_addr  = in_addr;
                        w_wdata = in_wdata;
                        w_rd    = in_rd;
                        w_wen   = in_wen;
                        w_we    = (in_op == c_OP_STORE);
                    end else begin
                        w_out_valid = 1'b1;
                        w_out_data  = in_addr;
                        w_out_rd    = in_rd;
                        w_out_wen   = in_wen;
                    end
                end
            end
            S_REQ: begin
                // Ack takes priority over a timeout on the same edge
                if (mem_ack) begin
                    w_state     = S_IDLE;
                    w_we        = 1'b0;
                    w_out_valid = 1'b1;
                    w_out_rd    = r_rd;
                    if (r_we) begin
                        w_out_data = r_addr;
                        w_out_wen  = 1'b0;
                    end else begin
                        w_out_data = mem_rdata;
                        w_out_wen  = r_wen;
                    end
                end else if (w_timeout) begin
                    w_state     = S_IDLE;
                    w_we        = 1'b0;
                    w_out_valid = 1'b1;
                    w_out_rd    = r_rd;
                    w_out_data  = 16'hFFFF;
                    w_out_wen   = r_we ? 1'b0 : r_wen;
                    w_err       = 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State and output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_rd        <= 4'h0;
            r_wen       <= 1'b0;
            r_we        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_rd    <= 4'h0;
            r_out_wen   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_rd        <= w_rd;
            r_wen       <= w_wen;
            r_we        <= w_we;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_out_rd    <= w_out_rd;
            r_out_wen   <= w_out_wen;
            r_err       <= w_err;
        end
    end

    assign stall     = (r_state == S_REQ);
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_rd    = r_out_rd;
    assign out_wen   = r_out_wen;
    assign err       = r_err;

endmodule
`default_nettype wire
